// File: rtl/ulpb_bus_ctrl_param_pkg.sv
// Shared definitions for the ULPB bus controller.
// Holds the FSM state encodings, the reset-cause codes and small helpers.
package ulpb_ctrl_defs;

  // FSM state encodings (4 bits). Odd codes drive CLK_OUT high, even codes low,
  // except IDLE, which keeps the bus clock parked high.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_START_HI = 4'd1;
  localparam logic [3:0] ST_START_LO = 4'd2;
  localparam logic [3:0] ST_ARB_HI   = 4'd3;
  localparam logic [3:0] ST_ARB_LO   = 4'd4;
  localparam logic [3:0] ST_D1_HI    = 4'd5;
  localparam logic [3:0] ST_D1_LO    = 4'd6;
  localparam logic [3:0] ST_L1_HI    = 4'd7;
  localparam logic [3:0] ST_L1_LO    = 4'd8;
  localparam logic [3:0] ST_D2_HI    = 4'd9;
  localparam logic [3:0] ST_D2_LO    = 4'd10;
  localparam logic [3:0] ST_L2_HI    = 4'd11;
  localparam logic [3:0] ST_L2_LO    = 4'd12;
  localparam logic [3:0] ST_RESET_HI = 4'd13;
  localparam logic [3:0] ST_RESET_LO = 4'd14;
  localparam logic [3:0] ST_DISABLE  = 4'd15;

  // Reason codes reported on RESET_CAUSE.
  localparam logic [1:0] CAUSE_NONE      = 2'd0;
  localparam logic [1:0] CAUSE_INTERJECT = 2'd1;
  localparam logic [1:0] CAUSE_WATCHDOG  = 2'd2;
  localparam logic [1:0] CAUSE_FORCED    = 2'd3;

  // Smallest width w >= 1 with 2^w >= value; sizes down-counters that hold value-1.
  function automatic int clog2_f(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // CLK_OUT level associated with a state.
  function automatic logic clk_level_f(input logic [3:0] st);
    logic lvl;
    if (st == ST_IDLE) begin
      lvl = 1'b1;
    end else begin
      lvl = st[0];
    end
    return lvl;
  endfunction

endpackage

// File: rtl/ulpb_bus_ctrl_param_din_filter.sv
// Ring data input stage: a single register (din_q) followed by a start
// glitch filter that only collects history while the controller is idle.
module ulpb_din_filter
  import ulpb_ctrl_defs::*;
#(
  parameter int GLITCH_LEN = 4
) (
  input  logic CLK_IN,
  input  logic RESET,
  input  logic DIN,
  input  logic ENABLE,
  output logic DIN_Q,
  output logic START_DET
);

  logic                  din_q_r;
  logic [GLITCH_LEN-1:0] shift_r;
  logic [GLITCH_LEN-1:0] shift_nxt_s;

  generate
    if (GLITCH_LEN == 1) begin : g_single
      // Single-sample filter: history is just the newest sample.
      always_comb begin
        shift_nxt_s = din_q_r;
      end
    end else begin : g_multi
      // Newest sample enters at bit 0, oldest drops off the top.
      always_comb begin
        shift_nxt_s = {shift_r[GLITCH_LEN-2:0], din_q_r};
      end
    end
  endgenerate

  // Register ring data once; the bus idles high.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      din_q_r <= 1'b1;
    end else begin
      din_q_r <= DIN;
    end
  end

  // Collect low-sample history in IDLE, otherwise hold the filter preset to ones.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      shift_r <= {GLITCH_LEN{1'b1}};
    end else if (ENABLE) begin
      shift_r <= shift_nxt_s;
    end else begin
      shift_r <= {GLITCH_LEN{1'b1}};
    end
  end

  assign DIN_Q     = din_q_r;
  assign START_DET = ENABLE & (shift_r == {GLITCH_LEN{1'b0}});

endmodule

// File: rtl/ulpb_bus_ctrl_param.sv
// ULPB ring clock master: start detection, clock phase generation, data
// forwarding, interjection / watchdog / forced bus resets and status outputs.
module ulpb_bus_ctrl_param
  import ulpb_ctrl_defs::*;
#(
  parameter int CLK_DIV             = 10,
  parameter int GLITCH_LEN          = 4,
  parameter int START_HALF_CYCLES   = 6,
  parameter int RESET_CYCLES        = 4,
  parameter int DISABLE_HALF_CYCLES = 6,
  parameter int MAX_BITS            = 1024,
  parameter int BCNT_W              = 11
) (
  input  logic              CLK_IN,
  input  logic              RESET,
  input  logic              DIN,
  output logic              DOUT,
  output logic              CLK_OUT,
  input  logic              FORCE_RESET,
  output logic              BUSY,
  output logic              RESET_PULSE,
  output logic [1:0]        RESET_CAUSE,
  output logic [BCNT_W-1:0] BIT_COUNT
);

  localparam int PH_W    = clog2_f(CLK_DIV);
  localparam int REP_MAX = (START_HALF_CYCLES > RESET_CYCLES) ?
                           ((START_HALF_CYCLES > DISABLE_HALF_CYCLES) ? START_HALF_CYCLES : DISABLE_HALF_CYCLES) :
                           ((RESET_CYCLES > DISABLE_HALF_CYCLES) ? RESET_CYCLES : DISABLE_HALF_CYCLES);
  localparam int REP_W   = clog2_f(REP_MAX);

  localparam logic [PH_W-1:0]   PH_RELOAD   = PH_W'(CLK_DIV - 1);
  localparam logic [REP_W-1:0]  REP_START   = REP_W'(START_HALF_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_RESET   = REP_W'(RESET_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_DISABLE = REP_W'(DISABLE_HALF_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_SAT    = {BCNT_W{1'b1}};
  localparam logic [BCNT_W:0]   MAX_BITS_C  = (BCNT_W + 1)'(MAX_BITS);

  logic [3:0]        state_r,  state_nxt_s;
  logic [PH_W-1:0]   ph_r,     ph_nxt_s;
  logic [REP_W-1:0]  rep_r,    rep_nxt_s;
  logic              hold_r,   hold_nxt_s;
  logic              force_r,  force_nxt_s;
  logic [1:0]        pend_r,   pend_nxt_s;
  logic [1:0]        cause_r,  cause_nxt_s;
  logic [BCNT_W-1:0] bcnt_r,   bcnt_nxt_s;
  logic              s1_r,     s1_nxt_s;
  logic              s2_r,     s2_nxt_s;
  logic              pulse_r,  pulse_nxt_s;
  logic              clk_out_r;
  logic              dout_r;
  logic              busy_r;

  logic              din_q_s;
  logic              start_s;
  logic              tick_s;
  logic              idle_s;
  logic [BCNT_W:0]   bcnt_inc_s;
  logic [1:0]        decide_s;

  assign idle_s     = (state_r == ST_IDLE);
  assign tick_s     = (ph_r == {PH_W{1'b0}});
  assign bcnt_inc_s = {1'b0, bcnt_r} + {{BCNT_W{1'b0}}, 1'b1};

  ulpb_din_filter #(
    .GLITCH_LEN (GLITCH_LEN)
  ) u_din_filter (
    .CLK_IN    (CLK_IN),
    .RESET     (RESET),
    .DIN       (DIN),
    .ENABLE    (idle_s),
    .DIN_Q     (din_q_s),
    .START_DET (start_s)
  );

  // Bus-reset decision for the current bit slot; forced beats interjection beats watchdog.
  always_comb begin
    decide_s = CAUSE_NONE;
    if (force_r) begin
      decide_s = CAUSE_FORCED;
    end else if (s1_r != s2_r) begin
      decide_s = CAUSE_INTERJECT;
    end else if (bcnt_inc_s >= MAX_BITS_C) begin
      decide_s = CAUSE_WATCHDOG;
    end else begin
      decide_s = CAUSE_NONE;
    end
  end

  // Next-state logic: phase timing, state sequencing and per-state side effects.
  always_comb begin
    state_nxt_s = state_r;
    ph_nxt_s    = ph_r;
    rep_nxt_s   = rep_r;
    hold_nxt_s  = hold_r;
    pend_nxt_s  = pend_r;
    cause_nxt_s = cause_r;
    bcnt_nxt_s  = bcnt_r;
    s1_nxt_s    = s1_r;
    s2_nxt_s    = s2_r;
    pulse_nxt_s = 1'b0;
    if (idle_s) begin
      if (start_s) begin
        state_nxt_s = ST_START_HI;
        ph_nxt_s    = PH_RELOAD;
        rep_nxt_s   = REP_START;
        bcnt_nxt_s  = {BCNT_W{1'b0}};
        cause_nxt_s = CAUSE_NONE;
      end else begin
        ph_nxt_s = ph_r;
      end
    end else if (tick_s) begin
      ph_nxt_s = PH_RELOAD;
      case (state_r)
        ST_START_HI: begin
          if (rep_r == {REP_W{1'b0}}) begin
            state_nxt_s = ST_START_LO;
          end else begin
            rep_nxt_s = rep_r - REP_W'(1);
          end
        end
        ST_START_LO: state_nxt_s = ST_ARB_HI;
        ST_ARB_HI:   state_nxt_s = ST_ARB_LO;
        ST_ARB_LO: begin
          state_nxt_s = ST_D1_HI;
          hold_nxt_s  = 1'b0;
        end
        ST_D1_HI:    state_nxt_s = ST_D1_LO;
        ST_D1_LO: begin
          state_nxt_s = ST_L1_HI;
          s1_nxt_s    = din_q_s;
        end
        ST_L1_HI:    state_nxt_s = ST_L1_LO;
        ST_L1_LO:    state_nxt_s = ST_D2_HI;
        ST_D2_HI:    state_nxt_s = ST_D2_LO;
        ST_D2_LO: begin
          state_nxt_s = ST_L2_HI;
          s2_nxt_s    = din_q_s;
        end
        ST_L2_HI: begin
          state_nxt_s = ST_L2_LO;
          pend_nxt_s  = decide_s;
        end
        ST_L2_LO: begin
          if (bcnt_r != BCNT_SAT) begin
            bcnt_nxt_s = bcnt_r + BCNT_W'(1);
          end else begin
            bcnt_nxt_s = bcnt_r;
          end
          if (pend_r != CAUSE_NONE) begin
            state_nxt_s = ST_RESET_HI;
            rep_nxt_s   = REP_RESET;
            pulse_nxt_s = 1'b1;
            cause_nxt_s = pend_r;
            pend_nxt_s  = CAUSE_NONE;
            hold_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_D1_HI;
          end
        end
        ST_RESET_HI: state_nxt_s = ST_RESET_LO;
        ST_RESET_LO: begin
          if (rep_r == {REP_W{1'b0}}) begin
            state_nxt_s = ST_DISABLE;
            rep_nxt_s   = REP_DISABLE;
          end else begin
            state_nxt_s = ST_RESET_HI;
            rep_nxt_s   = rep_r - REP_W'(1);
          end
        end
        ST_DISABLE: begin
          if (rep_r == {REP_W{1'b0}}) begin
            state_nxt_s = ST_IDLE;
          end else begin
            rep_nxt_s = rep_r - REP_W'(1);
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      ph_nxt_s = ph_r - PH_W'(1);
    end
  end

  // Force latch: ignored in IDLE, discarded during reset/disable, cleared when acted on.
  always_comb begin
    force_nxt_s = force_r;
    case (state_r)
      ST_IDLE, ST_RESET_HI, ST_RESET_LO, ST_DISABLE: force_nxt_s = 1'b0;
      default: begin
        if (pulse_nxt_s) begin
          force_nxt_s = 1'b0;
        end else if (FORCE_RESET) begin
          force_nxt_s = 1'b1;
        end else begin
          force_nxt_s = force_r;
        end
      end
    endcase
  end

  // Controller state and status registers.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      ph_r    <= PH_RELOAD;
      rep_r   <= {REP_W{1'b0}};
      hold_r  <= 1'b1;
      force_r <= 1'b0;
      pend_r  <= CAUSE_NONE;
      cause_r <= CAUSE_NONE;
      bcnt_r  <= {BCNT_W{1'b0}};
      s1_r    <= 1'b1;
      s2_r    <= 1'b1;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ph_r    <= ph_nxt_s;
      rep_r   <= rep_nxt_s;
      hold_r  <= hold_nxt_s;
      force_r <= force_nxt_s;
      pend_r  <= pend_nxt_s;
      cause_r <= cause_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      s1_r    <= s1_nxt_s;
      s2_r    <= s2_nxt_s;
      pulse_r <= pulse_nxt_s;
    end
  end

  // Bus-facing outputs registered alongside the state; DOUT mirrors din_q unless held.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      clk_out_r <= 1'b1;
      dout_r    <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      clk_out_r <= clk_level_f(state_nxt_s);
      dout_r    <= hold_nxt_s ? 1'b1 : DIN;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign CLK_OUT     = clk_out_r;
  assign DOUT        = dout_r;
  assign BUSY        = busy_r;
  assign RESET_PULSE = pulse_r;
  assign RESET_CAUSE = cause_r;
  assign BIT_COUNT   = bcnt_r;

endmodule
